// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite master bridge: converts level read/write requests from the dot-product
// engine into single-beat AXI-Lite transactions on independent read/write channels.
module axi_lite_master_bridge #(
    parameter int TIMEOUT_EN = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        read_req,
    input  logic [31:0] read_addr,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        write_req,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    output logic        write_done,
    input  logic        err_clr,
    output logic [1:0]  err_out,
    output logic        rd_busy,
    output logic        wr_busy,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready
);

    // Reserved for a future response timeout; intentionally has no logic behind it.
    if (TIMEOUT_EN != 0) begin : g_timeout_reserved
    end

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_HOLD} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_HOLD} w_state_t;

    r_state_t    r_state, r_state_n;
    w_state_t    w_state, w_state_n;
    logic [31:0] araddr_n, rdata_n, awaddr_n, wdata_n;
    logic        arvalid_n, rready_n, rdv_n;
    logic        awvalid_n, wvalid_n, bready_n, wdone_n;
    logic        rd_err, wr_err;
    logic [1:0]  err_n;

    always_comb begin
        r_state_n = r_state;
        araddr_n  = m_araddr;
        arvalid_n = m_arvalid;
        rready_n  = m_rready;
        rdata_n   = read_data;
        rdv_n     = 1'b0;
        rd_err    = 1'b0;
        case (r_state)
            R_IDLE: if (read_req) begin
                araddr_n  = read_addr;
                arvalid_n = 1'b1;
                r_state_n = R_ADDR;
            end
            R_ADDR: if (m_arvalid && m_arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                r_state_n = R_DATA;
            end
            R_DATA: if (m_rvalid && m_rready) begin
                rdata_n   = m_rdata;
                rdv_n     = 1'b1;
                rready_n  = 1'b0;
                rd_err    = (m_rresp != 2'b00);
                r_state_n = R_HOLD;
            end
            // One dead cycle lets the requester move read_addr/drop read_req.
            R_HOLD: r_state_n = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_n = w_state;
        awaddr_n  = m_awaddr;
        wdata_n   = m_wdata;
        awvalid_n = m_awvalid;
        wvalid_n  = m_wvalid;
        bready_n  = m_bready;
        wdone_n   = 1'b0;
        wr_err    = 1'b0;
        case (w_state)
            W_IDLE: if (write_req) begin
                awaddr_n  = write_addr;
                wdata_n   = write_data;
                awvalid_n = 1'b1;
                wvalid_n  = 1'b1;
                w_state_n = W_XFER;
            end
            W_XFER: begin
                // A channel whose valid is already low finished its handshake earlier.
                awvalid_n = m_awvalid && !m_awready;
                wvalid_n  = m_wvalid && !m_wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n  = 1'b1;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: if (m_bvalid && m_bready) begin
                bready_n  = 1'b0;
                wdone_n   = 1'b1;
                wr_err    = (m_bresp != 2'b00);
                w_state_n = W_HOLD;
            end
            W_HOLD: w_state_n = W_IDLE;
        endcase
    end

    // A fresh error outranks a simultaneous clear.
    always_comb begin
        err_n = err_clr ? 2'b00 : err_out;
        if (rd_err) err_n[0] = 1'b1;
        if (wr_err) err_n[1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        m_arprot <= 3'b000;
        m_awprot <= 3'b000;
        if (!resetn) begin
            r_state         <= R_IDLE;
            w_state         <= W_IDLE;
            m_araddr        <= '0;
            m_arvalid       <= 1'b0;
            m_rready        <= 1'b0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            m_awaddr        <= '0;
            m_wdata         <= '0;
            m_wstrb         <= 4'h0;
            m_awvalid       <= 1'b0;
            m_wvalid        <= 1'b0;
            m_bready        <= 1'b0;
            write_done      <= 1'b0;
            err_out         <= 2'b00;
            rd_busy         <= 1'b0;
            wr_busy         <= 1'b0;
        end else begin
            r_state         <= r_state_n;
            w_state         <= w_state_n;
            m_araddr        <= araddr_n;
            m_arvalid       <= arvalid_n;
            m_rready        <= rready_n;
            read_data       <= rdata_n;
            read_data_valid <= rdv_n;
            m_awaddr        <= awaddr_n;
            m_wdata         <= wdata_n;
            m_wstrb         <= 4'hF;
            m_awvalid       <= awvalid_n;
            m_wvalid        <= wvalid_n;
            m_bready        <= bready_n;
            write_done      <= wdone_n;
            err_out         <= err_n;
            rd_busy         <= (r_state_n != R_IDLE);
            wr_busy         <= (w_state_n != W_IDLE);
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: behavioural AXI-Lite slave, vector table,
// hand-written corner sequences and a randomized run against a sticky-error model.
module tb_axi_lite_master_bridge;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        read_req = 1'b0, write_req = 1'b0, err_clr = 1'b0;
    logic [31:0] read_addr = '0, write_addr = '0, write_data = '0;
    logic [31:0] read_data;
    logic        read_data_valid, write_done, rd_busy, wr_busy;
    logic [1:0]  err_out;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [2:0]  m_arprot, m_awprot;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic        m_arready = 1'b0, m_rvalid = 1'b0, m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0, m_bresp = '0;

    always #5 clk = ~clk;

    axi_lite_master_bridge #(.TIMEOUT_EN(0)) dut (
        .clk(clk), .resetn(resetn),
        .read_req(read_req), .read_addr(read_addr), .read_data(read_data),
        .read_data_valid(read_data_valid),
        .write_req(write_req), .write_addr(write_addr), .write_data(write_data),
        .write_done(write_done), .err_clr(err_clr), .err_out(err_out),
        .rd_busy(rd_busy), .wr_busy(wr_busy),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave configuration and observation logs
    int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    logic [31:0] ar_log[$], aw_log[$], w_log[$];
    int          rdv_cnt = 0, wdone_cnt = 0, proto_err = 0;

    initial begin : rd_slave
        int ar_cnt, r_cnt;
        bit r_pend, ar_pend, rst;
        logic [31:0] ar_prev;
        ar_cnt = 0; r_cnt = 0; r_pend = 0; ar_pend = 0; ar_prev = '0;
        forever begin
            @(posedge clk);
            rst = !resetn;
            if (rst) begin
                r_pend = 0; ar_pend = 0;
            end else begin
                if (ar_pend && (!m_arvalid || m_araddr != ar_prev)) proto_err++;
                if (m_arvalid && m_arready) begin ar_log.push_back(m_araddr); r_pend = 1; end
                if (m_rvalid && m_rready) r_pend = 0;
                if (read_data_valid) rdv_cnt++;
                ar_pend = m_arvalid && !m_arready;
                ar_prev = m_araddr;
            end
            #1;
            if (rst) begin
                m_arready = 0; m_rvalid = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
                else begin m_arready = 0; ar_cnt = 0; end
                if (r_pend) begin
                    m_rvalid = (r_cnt >= r_dly); m_rdata = s_rdata; m_rresp = s_rresp; r_cnt++;
                end else begin
                    m_rvalid = 0; r_cnt = 0;
                end
            end
        end
    end

    initial begin : wr_slave
        int aw_cnt, w_cnt, b_cnt;
        bit aw_done, w_done, aw_pend, w_pend, rst;
        logic [31:0] aw_prev, w_prev;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; aw_done = 0; w_done = 0; aw_pend = 0; w_pend = 0;
        aw_prev = '0; w_prev = '0;
        forever begin
            @(posedge clk);
            rst = !resetn;
            if (rst) begin
                aw_done = 0; w_done = 0; aw_pend = 0; w_pend = 0;
            end else begin
                if (aw_pend && (!m_awvalid || m_awaddr != aw_prev)) proto_err++;
                if (w_pend && (!m_wvalid || m_wdata != w_prev)) proto_err++;
                if (m_bready && !(aw_done && w_done)) proto_err++;
                if (m_bvalid && m_bready) begin aw_done = 0; w_done = 0; end
                if (m_awvalid && m_awready) begin aw_log.push_back(m_awaddr); aw_done = 1; end
                if (m_wvalid && m_wready) begin
                    w_log.push_back(m_wdata); w_done = 1;
                    if (m_wstrb != 4'hF || m_awprot != 3'b000 || m_arprot != 3'b000) proto_err++;
                end
                if (write_done) wdone_cnt++;
                aw_pend = m_awvalid && !m_awready; aw_prev = m_awaddr;
                w_pend  = m_wvalid && !m_wready;   w_prev  = m_wdata;
            end
            #1;
            if (rst) begin
                m_awready = 0; m_wready = 0; m_bvalid = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin m_awready = 0; aw_cnt = 0; end
                if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
                else begin m_wready = 0; w_cnt = 0; end
                if (aw_done && w_done) begin
                    m_bvalid = (b_cnt >= b_dly); m_bresp = s_bresp; b_cnt++;
                end else begin
                    m_bvalid = 0; b_cnt = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " read_data"}, read_data, 0);
        check({tag, " araddr"}, m_araddr, 0);
        check({tag, " awaddr"}, m_awaddr, 0);
        check({tag, " wdata"}, m_wdata, 0);
        check({tag, " ctl"}, {read_data_valid, write_done, err_out, rd_busy, wr_busy, m_arprot,
              m_arvalid, m_rready, m_awprot, m_awvalid, m_wstrb, m_wvalid, m_bready}, 0);
    endtask

    task automatic do_read(input logic [31:0] addr);
        bit ok = 0;
        read_addr = addr; read_req = 1;
        tick(1);
        check("rd N+1 arvalid/busy/addr", {m_arvalid, rd_busy, m_araddr == addr}, 3'b111);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (read_data_valid) begin ok = 1; break; end
        end
        read_req = 0;
        check("rd completes", ok, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        bit ok = 0;
        write_addr = addr; write_data = data; write_req = 1;
        tick(1);
        check("wr N+1 valids/busy/strb", {m_awvalid, m_wvalid, wr_busy, m_wstrb}, 7'h7F);
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (write_done) begin ok = 1; break; end
        end
        write_req = 0;
        check("wr completes", ok, 1);
    endtask

    task automatic clr_err();
        err_clr = 1; tick(1); err_clr = 0;
        check("err_clr", err_out, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        int          d1, d2;
        logic [1:0]  exp_err;
    } vec_t;

    logic [1:0] model_err;

    initial begin
        vec_t vt [6];
        int n_ar, n_aw, n_rd, n_wd;
        bit ok;
        logic [31:0] ra, rd, wa, wd;
        int op;

        vt[0] = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 2, 3, 2'b00};
        vt[1] = '{1'b1, 32'h0000_0200, 32'h1234_5678, 2'b00, 3, 0, 2'b00};
        vt[2] = '{1'b0, 32'h0000_0040, 32'hCAFE_F00D, 2'b10, 0, 0, 2'b01};
        vt[3] = '{1'b1, 32'h0000_0044, 32'h0BAD_0BAD, 2'b11, 0, 2, 2'b10};
        vt[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2'b00, 0, 0, 2'b00};
        vt[5] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 1, 1, 2'b10};

        // Reset state
        tick(3);
        check_idle_zero("reset");
        resetn = 1;
        tick(2);

        // Table-driven single transactions
        foreach (vt[k]) begin
            clr_err();
            n_ar = ar_log.size(); n_aw = aw_log.size(); n_rd = rdv_cnt; n_wd = wdone_cnt;
            if (vt[k].wr) begin
                aw_dly = vt[k].d1; w_dly = vt[k].d2; b_dly = 1; s_bresp = vt[k].resp;
                do_write(vt[k].addr, vt[k].data);
                tick(3);
                check("vec wdone pulses", wdone_cnt - n_wd, 1);
                check("vec aw count", aw_log.size() - n_aw, 1);
                check("vec aw addr", aw_log[$], vt[k].addr);
                check("vec w data", w_log[$], vt[k].data);
            end else begin
                ar_dly = vt[k].d1; r_dly = vt[k].d2; s_rdata = vt[k].data; s_rresp = vt[k].resp;
                do_read(vt[k].addr);
                tick(3);
                check("vec rdv pulses", rdv_cnt - n_rd, 1);
                check("vec ar count", ar_log.size() - n_ar, 1);
                check("vec ar addr", ar_log[$], vt[k].addr);
                check("vec read_data", read_data, vt[k].data);
            end
            check("vec err_out", err_out, vt[k].exp_err);
        end
        clr_err();

        // Back-to-back reads with read_req held high
        ar_dly = 0; r_dly = 1; s_rresp = 0; s_rdata = 32'hA5A5_0001;
        n_ar = ar_log.size();
        read_addr = 32'h0; read_req = 1;
        for (int j = 0; j < 2; j++) begin
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                tick(1);
                if (read_data_valid) begin ok = 1; break; end
            end
            check("b2b rdv seen", ok, 1);
            if (j == 0) read_addr = 32'h8;
            else read_req = 0;
        end
        tick(6);
        check("b2b ar count", ar_log.size() - n_ar, 2);
        check("b2b ar0", ar_log[n_ar], 32'h0);
        check("b2b ar1", ar_log[n_ar + 1], 32'h8);
        check("b2b rd_busy idle", rd_busy, 0);

        // Request pulsed for one cycle still completes
        ar_dly = 3; n_ar = ar_log.size();
        read_addr = 32'h30; read_req = 1; tick(1); read_req = 0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (read_data_valid) begin ok = 1; break; end
        end
        check("drop req completes", ok, 1);
        tick(3);
        check("drop req ar addr", ar_log[$], 32'h30);
        check("drop req ar count", ar_log.size() - n_ar, 1);

        // Errors accumulate, clear, and a coincident set beats clear
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        s_rresp = 2'b10; s_bresp = 2'b11;
        fork
            do_read(32'h50);
            do_write(32'h54, 32'h5555_AAAA);
        join
        tick(3);
        check("err both", err_out, 2'b11);
        clr_err();
        err_clr = 1;
        do_read(32'h58);
        err_clr = 0;
        check("err set wins over clr", err_out, 2'b01);
        tick(3);
        clr_err();

        // Reset while in R_DATA
        s_rresp = 0; ar_dly = 0; r_dly = 30;
        read_addr = 32'h60; read_req = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (m_rready) begin ok = 1; break; end
        end
        check("reached R_DATA", ok, 1);
        read_req = 0; resetn = 0;
        tick(1);
        check_idle_zero("mid-read reset");
        resetn = 1; r_dly = 0;
        tick(2);
        s_rdata = 32'h7777_1234;
        do_read(32'h64);
        tick(3);
        check("post-reset read", read_data, 32'h7777_1234);

        // Randomized concurrent traffic against a sticky-error model
        model_err = 2'b00;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) begin clr_err(); model_err = 2'b00; end
            ra = $urandom & ~32'h3; rd = $urandom; wa = $urandom & ~32'h3; wd = $urandom;
            ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4);
            s_rdata = rd;
            s_rresp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            s_bresp = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            n_rd = rdv_cnt; n_wd = wdone_cnt;
            if (op != 1 && s_rresp != 0) model_err[0] = 1'b1;
            if (op != 0 && s_bresp != 0) model_err[1] = 1'b1;
            case (op)
                0: do_read(ra);
                1: do_write(wa, wd);
                default: fork do_read(ra); do_write(wa, wd); join
            endcase
            tick(3);
            if (op != 1) begin
                check("rnd read_data", read_data, rd);
                check("rnd ar addr", ar_log[$], ra);
                check("rnd rdv pulses", rdv_cnt - n_rd, 1);
            end
            if (op != 0) begin
                check("rnd aw addr", aw_log[$], wa);
                check("rnd w data", w_log[$], wd);
                check("rnd wdone pulses", wdone_cnt - n_wd, 1);
            end
            check("rnd err_out", err_out, model_err);
            check("rnd idle", {rd_busy, wr_busy}, 0);
        end

        check("protocol violations", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
